// File: rtl/avalon_ibex_translator_pipelined_if.sv
// Core data-port and Avalon-MM signal bundle seen by the translator ("slave" side) and its environment ("master" side).
interface avalon_ibex_translator_pipelined_if #(
    parameter int DataWidth = 64,
    parameter int AddrWidth = 32
);
    logic                   data_req_i;
    logic                   data_we_i;
    logic [DataWidth/8-1:0] data_be_i;
    logic [AddrWidth-1:0]   data_addr_i;
    logic [DataWidth-1:0]   data_wdata_i;
    logic                   data_gnt_o;
    logic                   data_rvalid_o;
    logic [DataWidth-1:0]   data_rdata_o;
    logic                   data_err_o;
    logic [AddrWidth-1:0]   avm_address;
    logic [DataWidth/8-1:0] avm_byteenable;
    logic                   avm_read;
    logic                   avm_write;
    logic [DataWidth-1:0]   avm_writedata;
    logic                   avm_waitrequest;
    logic                   avm_readdatavalid;
    logic [DataWidth-1:0]   avm_readdata;
    logic [1:0]             avm_response;

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        input  avm_waitrequest, avm_readdatavalid, avm_readdata, avm_response
    );

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        output avm_waitrequest, avm_readdatavalid, avm_readdata, avm_response
    );
endinterface

// File: rtl/avalon_ibex_translator_pipelined.sv
// ibex LSU to Avalon-MM master, up to MaxOutstanding pipelined transactions, responses retired in grant order.
// Latency: write gnt N -> rvalid N+2; readdatavalid M -> rvalid M+2 (head of queue).
// Backpressure: no grant while waitrequest is high or tracking queue is full; read returns cannot be stalled.
module avalon_ibex_translator_pipelined #(
    parameter int DataWidth      = 64,
    parameter int AddrWidth      = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    avalon_ibex_translator_pipelined_if.slave       bus,
    output logic [$clog2(MaxOutstanding+1)-1:0]     outstanding_o
);
    localparam int BeW  = DataWidth / 8;
    localparam int OffW = $clog2(BeW);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    logic [MaxOutstanding-1:0] trk_we_q, trk_we_d;
    logic [PtrW-1:0]           trk_wptr_q, trk_wptr_d, trk_rptr_q, trk_rptr_d;
    logic [CntW-1:0]           trk_cnt_q, trk_cnt_d;
    logic [CntW-1:0]           rd_pend_q, rd_pend_d;
    logic [DataWidth-1:0]      rdf_data_q [MaxOutstanding];
    logic [DataWidth-1:0]      rdf_data_d [MaxOutstanding];
    logic [MaxOutstanding-1:0] rdf_err_q, rdf_err_d;
    logic [PtrW-1:0]           rdf_wptr_q, rdf_wptr_d, rdf_rptr_q, rdf_rptr_d;
    logic [CntW-1:0]           rdf_cnt_q, rdf_cnt_d;
    logic                      rvalid_q, rvalid_d, err_q, err_d;
    logic [DataWidth-1:0]      rdata_q, rdata_d;

    logic full, cmd_rd, cmd_wr, gnt, ret_wr, ret_rd, retire, rdf_push;

    assign full   = (trk_cnt_q == MaxCnt);
    assign cmd_rd = bus.data_req_i & ~bus.data_we_i & ~full;
    assign cmd_wr = bus.data_req_i &  bus.data_we_i & ~full;
    assign gnt    = (cmd_rd | cmd_wr) & ~bus.avm_waitrequest;

    assign bus.avm_read       = cmd_rd;
    assign bus.avm_write      = cmd_wr;
    assign bus.avm_address    = {bus.data_addr_i[AddrWidth-1:OffW], {OffW{1'b0}}};
    assign bus.avm_byteenable = bus.data_be_i;
    assign bus.avm_writedata  = bus.data_wdata_i;
    assign bus.data_gnt_o     = gnt;

    // Retire decision uses registered queue state only, so a return lands no earlier than the next cycle.
    assign ret_wr = (trk_cnt_q != '0) &  trk_we_q[trk_rptr_q];
    assign ret_rd = (trk_cnt_q != '0) & ~trk_we_q[trk_rptr_q] & (rdf_cnt_q != '0);
    assign retire = ret_wr | ret_rd;

    // Returns with no unretired read waiting for them (e.g. issued before a reset) are discarded.
    assign rdf_push = bus.avm_readdatavalid & (rd_pend_q > rdf_cnt_q);

    always_comb begin
        trk_we_d   = trk_we_q;
        trk_wptr_d = trk_wptr_q;
        trk_rptr_d = trk_rptr_q;
        trk_cnt_d  = trk_cnt_q;
        rd_pend_d  = rd_pend_q;
        if (gnt) begin
            trk_we_d[trk_wptr_q] = bus.data_we_i;
            trk_wptr_d           = ptr_inc(trk_wptr_q);
        end
        if (retire) trk_rptr_d = ptr_inc(trk_rptr_q);
        case ({gnt, retire})
            2'b10:   trk_cnt_d = trk_cnt_q + CntW'(1);
            2'b01:   trk_cnt_d = trk_cnt_q - CntW'(1);
            default: trk_cnt_d = trk_cnt_q;
        endcase
        case ({gnt & ~bus.data_we_i, ret_rd})
            2'b10:   rd_pend_d = rd_pend_q + CntW'(1);
            2'b01:   rd_pend_d = rd_pend_q - CntW'(1);
            default: rd_pend_d = rd_pend_q;
        endcase
    end

    always_comb begin
        rdf_data_d = rdf_data_q;
        rdf_err_d  = rdf_err_q;
        rdf_wptr_d = rdf_wptr_q;
        rdf_rptr_d = rdf_rptr_q;
        rdf_cnt_d  = rdf_cnt_q;
        if (rdf_push) begin
            rdf_data_d[rdf_wptr_q] = bus.avm_readdata;
            rdf_err_d[rdf_wptr_q]  = (bus.avm_response != 2'b00);
            rdf_wptr_d             = ptr_inc(rdf_wptr_q);
        end
        if (ret_rd) rdf_rptr_d = ptr_inc(rdf_rptr_q);
        case ({rdf_push, ret_rd})
            2'b10:   rdf_cnt_d = rdf_cnt_q + CntW'(1);
            2'b01:   rdf_cnt_d = rdf_cnt_q - CntW'(1);
            default: rdf_cnt_d = rdf_cnt_q;
        endcase
    end

    always_comb begin
        rvalid_d = retire;
        rdata_d  = ret_rd ? rdf_data_q[rdf_rptr_q] : '0;
        err_d    = ret_rd & rdf_err_q[rdf_rptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trk_we_q   <= '0;
            trk_wptr_q <= '0;
            trk_rptr_q <= '0;
            trk_cnt_q  <= '0;
            rd_pend_q  <= '0;
            for (int i = 0; i < MaxOutstanding; i++) rdf_data_q[i] <= '0;
            rdf_err_q  <= '0;
            rdf_wptr_q <= '0;
            rdf_rptr_q <= '0;
            rdf_cnt_q  <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            trk_we_q   <= trk_we_d;
            trk_wptr_q <= trk_wptr_d;
            trk_rptr_q <= trk_rptr_d;
            trk_cnt_q  <= trk_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rdf_data_q <= rdf_data_d;
            rdf_err_q  <= rdf_err_d;
            rdf_wptr_q <= rdf_wptr_d;
            rdf_rptr_q <= rdf_rptr_d;
            rdf_cnt_q  <= rdf_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.data_rvalid_o = rvalid_q;
    assign bus.data_rdata_o  = rdata_q;
    assign bus.data_err_o    = err_q;
    assign outstanding_o     = trk_cnt_q;
endmodule

// File: doc/avalon_ibex_translator_pipelined.md
Name: avalon_ibex_translator_pipelined

Overview:
Parametrised ibex-LSU-to-Avalon-MM master translator. It is the next generation of the single-outstanding main-memory translator.
It supports configurable data/address width and up to MaxOutstanding pipelined transactions. Read and write responses are returned to the core strictly in order, and a non-OKAY Avalon response is mapped to data_err_o.
It sits between ibex_core's data port and the Avalon main-memory interface in the Avalon core wrapper.

Parameters:
DataWidth, 64, data bus width in bits; multiple of 8, power of two ≥32.
AddrWidth, 32, byte address width.
MaxOutstanding, 4, max accepted-but-unretired transactions; ≥1.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
data_req_i  in  1  core request
data_we_i  in  1  1=write, 0=read
data_be_i  in  DataWidth/8  byte enables
data_addr_i  in  AddrWidth  byte address
data_wdata_i  in  DataWidth  write data
data_gnt_o  out  1  request accepted this cycle
data_rvalid_o  out  1  response valid (one cycle per transaction)
data_rdata_o  out  DataWidth  read data
data_err_o  out  1  response error, qualified by data_rvalid_o
avm_address  out  AddrWidth  byte address, low log2(DataWidth/8) bits forced 0
avm_byteenable  out  DataWidth/8  byte enables
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  DataWidth  write data
avm_waitrequest  in  1  slave stall
avm_readdatavalid  in  1  read data return
avm_readdata  in  DataWidth  read data
avm_response  in  2  00=OKAY, other=error
outstanding_o  out  $clog2(MaxOutstanding+1)  unretired transaction count

Behaviour:
- Clock clk_i only; rst_ni asynchronous active-low. All state clears on assertion, including mid-transaction.
- Reset values: data_rvalid_o=0, data_err_o=0, data_rdata_o=0, outstanding_o=0. Avalon command outputs are combinational from inputs and are 0 while data_req_i=0.
- full = (outstanding == MaxOutstanding).
- Command path (combinational):
  - avm_read = data_req_i & ~data_we_i & ~full
  - avm_write = data_req_i & data_we_i & ~full
  - address, byteenable and writedata pass through.
  - data_gnt_o = (avm_read|avm_write) & ~avm_waitrequest.
  - The core holds the request stable until gnt, which satisfies the Avalon hold-under-waitrequest rule.
- Tracking FIFO (depth MaxOutstanding, 1 bit = type):
  - Pushes on data_gnt_o with the we flag.
  - Pops on retire.
  - outstanding = entries present. Push and pop in the same cycle leave the count unchanged.
- Read-data FIFO (depth MaxOutstanding, DataWidth+1 bits = data, err):
  - Pushes on every avm_readdatavalid; err bit = (avm_response != 2'b00). It cannot be backpressured.
  - If avm_readdatavalid arrives while the number of unretired reads ≤ the read-data FIFO occupancy (a stray return, e.g. after reset), it is dropped and not stored.
- Retire (one per cycle max, evaluated on registered FIFO state):
  - Head is a write → retire with rdata=0, err=0.
  - Else head is a read and the read-data FIFO is non-empty → retire, popping both FIFOs.
  - Else nothing.
- Response stage: data_rvalid_o/rdata/err are registered from the retire decision. data_rvalid_o is high exactly one cycle per transaction.
- Latency:
  - Write granted in cycle N → data_rvalid_o in cycle N+2 (if nothing older is pending).
  - avm_readdatavalid in cycle M → data_rvalid_o in M+2 (if the read is at the head).
- Ordering: responses are in grant order. A write behind a pending read waits even though the write completed on Avalon.
- Full: while full, avm_read/avm_write=0 and data_gnt_o=0. A retire in that cycle frees a slot for the next cycle, not the same one.
- Simultaneous grant and retire with outstanding=MaxOutstanding cannot occur (no grant when full). Otherwise both are allowed in the same cycle.
- Error responses still return avm_readdata on data_rdata_o. There is no retry.

Test Plan:
- Single read, addr 0x8000_0004, waitrequest low, readdatavalid 3 cycles later with data 0x1122334455667788, resp 00 → avm_address=0x8000_0000; gnt in cycle 0; rvalid 2 cycles after readdatavalid with that data, err=0.
- 4 back-to-back reads with slave latency 5, MaxOutstanding=4 → 4 consecutive gnts; 5th request stalled with avm_read=0 until the first retire; outstanding_o peaks at 4; data returned in order.
- Read (latency 6) then write granted next cycle → write rvalid appears only in the cycle after the read rvalid; write rdata=0, err=0.
- Read with avm_response=2'b10 → data_rvalid_o=1, data_err_o=1 for one cycle, data_rdata_o=avm_readdata.
- waitrequest held high 7 cycles on a write (be=0x0F) → avm_write, address and data stable all 7 cycles; gnt only in cycle 8.
- Assert rst_ni low with 3 reads outstanding, release, then slave returns 3 stale readdatavalid → all dropped, no data_rvalid_o, outstanding_o=0; a new read then completes normally.
